// File: rtl/spi_slave_responder_if.sv
// Pin and local-logic bundle for spi_slave_responder.
// The overrun signal exists only when SPI_SLAVE_OVR_EN is defined.
interface spi_slave_responder_if;
    logic       cpol;
    logic       cpha;
    logic       lsbfe;
    logic       ss;
    logic       sclk;
    logic       mosi;
    logic       miso;
    logic       miso_oe;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_read;
    logic       busy;
`ifdef SPI_SLAVE_OVR_EN
    logic       overrun;

    modport slave (
        input  cpol, cpha, lsbfe, ss, sclk, mosi, tx_data, tx_valid, rx_read,
        output miso, miso_oe, tx_ready, rx_data, rx_valid, busy, overrun
    );
    modport master (
        output cpol, cpha, lsbfe, ss, sclk, mosi, tx_data, tx_valid, rx_read,
        input  miso, miso_oe, tx_ready, rx_data, rx_valid, busy, overrun
    );
`else
    modport slave (
        input  cpol, cpha, lsbfe, ss, sclk, mosi, tx_data, tx_valid, rx_read,
        output miso, miso_oe, tx_ready, rx_data, rx_valid, busy
    );
    modport master (
        output cpol, cpha, lsbfe, ss, sclk, mosi, tx_data, tx_valid, rx_read,
        input  miso, miso_oe, tx_ready, rx_data, rx_valid, busy
    );
`endif
endinterface

// File: rtl/spi_slave_responder.sv
// Oversampling SPI slave endpoint: 8-bit slots, all CPOL/CPHA modes, MSB/LSB first.
// Define SPI_SLAVE_OVR_EN to keep the oldest unread byte and flag a sticky overrun.
module spi_slave_responder (
    input  logic                 PCLK,
    input  logic                 PRESET,
    spi_slave_responder_if.slave bus
);
    localparam int unsigned DW = 8;
    localparam int unsigned CW = 3;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT} state_t;

    state_t          r_state;
    logic            r_ss_s1, r_busy;
    logic            r_sclk_s1, r_sclk_s2, r_sclk_s3;
    logic            r_mosi_s1, r_mosi_s2;
    logic            r_cpol, r_cpha, r_lsbfe, r_first;
    logic            r_miso, r_miso_oe, r_tx_ready, r_rx_valid;
    logic [DW-1:0]   r_tx_buf, r_tx_sr, r_rx_sr, r_rx_data;
    logic [CW-1:0]   r_cnt;
`ifdef SPI_SLAVE_OVR_EN
    logic            r_overrun;
`endif

    logic            w_rise, w_fall, w_lead, w_trail;
    logic            w_sample, w_drive, w_done, w_load, w_order;
    logic [DW-1:0]   w_src, w_tx_word, w_rx_next;

    function automatic logic [DW-1:0] bit_rev(input logic [DW-1:0] d);
        logic [DW-1:0] res;
        res = '0;
        for (int unsigned i = 0; i < DW; i++) res[i] = d[DW-1-i];
        return res;
    endfunction

    // Pin synchronizers; r_busy is the second ss stage stored inverted.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_ss_s1   <= 1'b1;
            r_busy    <= 1'b0;
            r_sclk_s1 <= bus.cpol;
            r_sclk_s2 <= bus.cpol;
            r_sclk_s3 <= bus.cpol;
            r_mosi_s1 <= 1'b0;
            r_mosi_s2 <= 1'b0;
        end else begin
            r_ss_s1   <= bus.ss;
            r_busy    <= ~r_ss_s1;
            r_sclk_s1 <= bus.sclk;
            r_sclk_s2 <= r_sclk_s1;
            r_sclk_s3 <= r_sclk_s2;
            r_mosi_s1 <= bus.mosi;
            r_mosi_s2 <= r_mosi_s1;
        end
    end

    always_comb begin
        w_rise    = r_sclk_s2 & ~r_sclk_s3;
        w_fall    = ~r_sclk_s2 & r_sclk_s3;
        w_lead    = r_cpol ? w_fall : w_rise;
        w_trail   = r_cpol ? w_rise : w_fall;
        w_sample  = (r_state == S_SHIFT) && r_busy && (r_cpha ? w_trail : w_lead);
        w_drive   = (r_state == S_SHIFT) && r_busy && (r_cpha ? w_lead : w_trail);
        w_rx_next = r_lsbfe ? {r_mosi_s2, r_rx_sr[DW-1:1]} : {r_rx_sr[DW-2:0], r_mosi_s2};
        w_done    = w_sample && (r_cnt == CW'(DW-1));
        w_load    = ((r_state == S_IDLE) && r_busy) || w_done;
        // Frame start uses the live ordering input, later slots the captured one.
        w_order   = (r_state == S_IDLE) ? bus.lsbfe : r_lsbfe;
        w_src     = r_tx_ready ? '1 : r_tx_buf;
        w_tx_word = w_order ? bit_rev(w_src) : w_src;
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state    <= S_IDLE;
            r_cpol     <= bus.cpol;
            r_cpha     <= 1'b0;
            r_lsbfe    <= 1'b0;
            r_first    <= 1'b0;
            r_miso     <= 1'b0;
            r_miso_oe  <= 1'b0;
            r_tx_ready <= 1'b1;
            r_tx_buf   <= '0;
            r_tx_sr    <= '0;
            r_rx_sr    <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_cnt      <= '0;
`ifdef SPI_SLAVE_OVR_EN
            r_overrun  <= 1'b0;
`endif
        end else begin
            // One-entry tx buffer: a load drains it, a write fills it only when empty.
            if (w_load && !r_tx_ready) begin
                r_tx_ready <= 1'b1;
            end else if (bus.tx_valid && r_tx_ready) begin
                r_tx_buf   <= bus.tx_data;
                r_tx_ready <= 1'b0;
            end

            if (w_done) begin
`ifdef SPI_SLAVE_OVR_EN
                if (r_rx_valid && !bus.rx_read) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_rx_data  <= w_rx_next;
                    r_rx_valid <= 1'b1;
                    if (bus.rx_read) r_overrun <= 1'b0;
                end
`else
                r_rx_data  <= w_rx_next;
                r_rx_valid <= 1'b1;
`endif
            end else if (bus.rx_read) begin
                r_rx_valid <= 1'b0;
`ifdef SPI_SLAVE_OVR_EN
                r_overrun  <= 1'b0;
`endif
            end

            case (r_state)
                S_IDLE: begin
                    r_miso    <= 1'b0;
                    r_miso_oe <= 1'b0;
                    r_cnt     <= '0;
                    r_first   <= 1'b0;
                    if (r_busy) begin
                        r_cpol    <= bus.cpol;
                        r_cpha    <= bus.cpha;
                        r_lsbfe   <= bus.lsbfe;
                        r_tx_sr   <= {w_tx_word[DW-2:0], 1'b0};
                        r_miso    <= w_tx_word[DW-1];
                        r_miso_oe <= 1'b1;
                        r_first   <= bus.cpha;
                        r_state   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (!r_busy) begin
                        r_miso    <= 1'b0;
                        r_miso_oe <= 1'b0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (!r_busy) begin
                        r_miso    <= 1'b0;
                        r_miso_oe <= 1'b0;
                        r_cnt     <= '0;
                        r_state   <= S_IDLE;
                    end else begin
                        if (w_sample) begin
                            r_rx_sr <= w_rx_next;
                            r_cnt   <= r_cnt + CW'(1);
                        end
                        // Reload keeps miso; the next drive edge presents the new first bit.
                        if (w_done) begin
                            r_tx_sr <= w_tx_word;
                            r_first <= 1'b0;
                        end
                        if (w_drive) begin
                            if (r_first) begin
                                r_first <= 1'b0;
                            end else begin
                                r_miso  <= r_tx_sr[DW-1];
                                r_tx_sr <= {r_tx_sr[DW-2:0], 1'b0};
                            end
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.miso     = r_miso;
    assign bus.miso_oe  = r_miso_oe;
    assign bus.tx_ready = r_tx_ready;
    assign bus.rx_data  = r_rx_data;
    assign bus.rx_valid = r_rx_valid;
    assign bus.busy     = r_busy;
`ifdef SPI_SLAVE_OVR_EN
    assign bus.overrun  = r_overrun;
`endif

endmodule

// File: tb/tb_spi_slave_responder.sv
// Self-checking bench for spi_slave_responder: directed vector table, corner
// sequences and randomized frames checked against a slot-level reference model.
module tb_spi_slave_responder;
    localparam int H = 8;

    logic PCLK = 1'b0;
    logic PRESET = 1'b1;
    always #5 PCLK = ~PCLK;

    spi_slave_responder_if ifc();
    spi_slave_responder dut (.PCLK(PCLK), .PRESET(PRESET), .bus(ifc));

    int n_checks = 0;
    int n_fail = 0;

    logic [7:0] tx_arr [0:63];
    int         tx_wr = 0;
    int         tx_rd = 0;
    logic [7:0] got_q [$];
    bit         auto_read = 1'b0;
    int         rd_req = 0;
    int         rd_done = 0;
    logic [7:0] m_tx [0:3];
    logic [7:0] m_rx [0:3];

    typedef struct {
        logic       pol, pha, lsb, pre;
        logic [7:0] tx, mo, exp_mi, exp_rx;
    } vec_t;
    vec_t tv [0:5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Local-side tx producer: writes queued bytes whenever the buffer is empty.
    initial begin
        ifc.tx_valid = 1'b0;
        ifc.tx_data  = 8'h00;
        forever begin
            @(negedge PCLK);
            if (ifc.tx_valid) ifc.tx_valid = 1'b0;
            else if (tx_rd != tx_wr && ifc.tx_ready && !PRESET) begin
                ifc.tx_data  = tx_arr[tx_rd % 64];
                ifc.tx_valid = 1'b1;
                tx_rd++;
            end
        end
    end

    // Local-side rx consumer: explicit read requests or automatic draining.
    initial begin
        ifc.rx_read = 1'b0;
        forever begin
            @(negedge PCLK);
            if (ifc.rx_read) ifc.rx_read = 1'b0;
            else if (rd_done != rd_req) begin
                ifc.rx_read = 1'b1;
                rd_done++;
            end else if (auto_read && ifc.rx_valid) begin
                got_q.push_back(ifc.rx_data);
                ifc.rx_read = 1'b1;
            end
        end
    end

    task automatic push_tx(input logic [7:0] b);
        tx_arr[tx_wr % 64] = b;
        tx_wr++;
    endtask

    task automatic wait_tx_drain(input string name);
        int t = 0;
        while ((tx_rd != tx_wr || ifc.tx_valid) && t < 400) begin
            @(negedge PCLK);
            t++;
        end
        if (t >= 400) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: tx write not accepted within 400 cycles", name);
        end
    endtask

    task automatic do_read();
        rd_req++;
        repeat (3) @(negedge PCLK);
    endtask

    // SPI master: nb bytes under one ss; stops after abort_bits bits if smaller.
    task automatic spi_frame(input logic pol, input logic pha, input logic lsb,
                             input int nb, input int abort_bits);
        int  bitn = 0;
        bit  stop = 1'b0;
        int  idx;
        ifc.cpol = pol; ifc.cpha = pha; ifc.lsbfe = lsb;
        ifc.sclk = pol; ifc.mosi = 1'b0;
        repeat (4) @(negedge PCLK);
        ifc.ss = 1'b0;
        repeat (6) @(negedge PCLK);
        for (int b = 0; b < nb && !stop; b++) begin
            m_rx[b] = 8'h00;
            for (int i = 0; i < 8; i++) begin
                if (bitn == abort_bits) begin stop = 1'b1; break; end
                idx = lsb ? i : 7 - i;
                if (!pha) begin
                    ifc.mosi = m_tx[b][idx];
                    repeat (H) @(negedge PCLK);
                    ifc.sclk = ~pol;
                    m_rx[b][idx] = ifc.miso;
                    repeat (H) @(negedge PCLK);
                    ifc.sclk = pol;
                end else begin
                    repeat (H) @(negedge PCLK);
                    ifc.sclk = ~pol;
                    ifc.mosi = m_tx[b][idx];
                    repeat (H) @(negedge PCLK);
                    m_rx[b][idx] = ifc.miso;
                    ifc.sclk = pol;
                end
                bitn++;
            end
        end
        repeat (H) @(negedge PCLK);
        ifc.ss = 1'b1;
        ifc.mosi = 1'b0;
        repeat (8) @(negedge PCLK);
    endtask

    task automatic check_reset(input string p);
        check({p, ".miso"},     32'(ifc.miso),     32'd0);
        check({p, ".miso_oe"},  32'(ifc.miso_oe),  32'd0);
        check({p, ".tx_ready"}, 32'(ifc.tx_ready), 32'd1);
        check({p, ".rx_data"},  32'(ifc.rx_data),  32'h00);
        check({p, ".rx_valid"}, 32'(ifc.rx_valid), 32'd0);
        check({p, ".busy"},     32'(ifc.busy),     32'd0);
`ifdef SPI_SLAVE_OVR_EN
        check({p, ".overrun"},  32'(ifc.overrun),  32'd0);
`endif
    endtask

    initial begin
        int g0, nb, m;
        logic [7:0] data [0:3];
        logic [7:0] exp_mi;
        logic pol, pha, lsb;

        tv[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
        tv[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h55, 8'hFF, 8'h55};
        tv[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h81, 8'h0F, 8'h81, 8'h0F};
        tv[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'hC3, 8'hE7, 8'hC3, 8'hE7};
        tv[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 8'h80, 8'h01, 8'h80};
        tv[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'hFF, 8'h00};

        ifc.ss = 1'b1; ifc.sclk = 1'b0; ifc.mosi = 1'b0;
        ifc.cpol = 1'b0; ifc.cpha = 1'b0; ifc.lsbfe = 1'b0;
        PRESET = 1'b1;
        repeat (3) @(negedge PCLK);
        PRESET = 1'b0;
        @(negedge PCLK);
        check_reset("reset");

        // Directed single-byte frames, rx left pending then read explicitly.
        for (int k = 0; k < 6; k++) begin
            if (tv[k].pre) begin
                push_tx(tv[k].tx);
                wait_tx_drain($sformatf("vec%0d.wr", k));
                check($sformatf("vec%0d.tx_ready_full", k), 32'(ifc.tx_ready), 32'd0);
            end
            m_tx[0] = tv[k].mo;
            spi_frame(tv[k].pol, tv[k].pha, tv[k].lsb, 1, 99);
            check($sformatf("vec%0d.master_rx", k), 32'(m_rx[0]), 32'(tv[k].exp_mi));
            check($sformatf("vec%0d.rx_data", k), 32'(ifc.rx_data), 32'(tv[k].exp_rx));
            check($sformatf("vec%0d.rx_valid", k), 32'(ifc.rx_valid), 32'd1);
            check($sformatf("vec%0d.tx_ready", k), 32'(ifc.tx_ready), 32'd1);
            check($sformatf("vec%0d.miso_oe_idle", k), 32'(ifc.miso_oe), 32'd0);
            do_read();
            check($sformatf("vec%0d.rx_valid_read", k), 32'(ifc.rx_valid), 32'd0);
        end

        // Mode 3, LSB first, two back-to-back bytes under one ss.
        auto_read = 1'b1;
        g0 = got_q.size();
        push_tx(8'h81);
        wait_tx_drain("b2b.wr");
        push_tx(8'h7E);
        m_tx[0] = 8'h12; m_tx[1] = 8'h34;
        spi_frame(1'b1, 1'b1, 1'b1, 2, 99);
        check("b2b.master_rx0", 32'(m_rx[0]), 32'h81);
        check("b2b.master_rx1", 32'(m_rx[1]), 32'h7E);
        check("b2b.rx_count", 32'(got_q.size() - g0), 32'd2);
        if (got_q.size() - g0 >= 2) begin
            check("b2b.rx0", 32'(got_q[g0]), 32'h12);
            check("b2b.rx1", 32'(got_q[g0+1]), 32'h34);
        end
        check("b2b.tx_ready", 32'(ifc.tx_ready), 32'd1);

        // ss raised after 5 bits, then a full frame.
        g0 = got_q.size();
        m_tx[0] = 8'hF0;
        spi_frame(1'b0, 1'b0, 1'b0, 1, 5);
        check("abort.no_rx", 32'(got_q.size() - g0), 32'd0);
        check("abort.rx_valid", 32'(ifc.rx_valid), 32'd0);
        check("abort.miso_oe", 32'(ifc.miso_oe), 32'd0);
        check("abort.miso", 32'(ifc.miso), 32'd0);
        m_tx[0] = 8'hC3;
        spi_frame(1'b0, 1'b0, 1'b0, 1, 99);
        check("abort.next_master_rx", 32'(m_rx[0]), 32'hFF);
        check("abort.next_rx_count", 32'(got_q.size() - g0), 32'd1);
        if (got_q.size() > g0) check("abort.next_rx", 32'(got_q[g0]), 32'hC3);

        // Randomized frames against a slot model: slot k sends supplied byte k or 0xFF.
        for (int r = 0; r < 12; r++) begin
            pol = 1'($urandom_range(0, 1));
            pha = 1'($urandom_range(0, 1));
            lsb = 1'($urandom_range(0, 1));
            nb  = int'($urandom_range(1, 3));
            m   = int'($urandom_range(0, nb));
            for (int k = 0; k < 4; k++) begin
                data[k] = 8'($urandom);
                m_tx[k] = 8'($urandom);
            end
            if (m > 0) begin
                push_tx(data[0]);
                wait_tx_drain($sformatf("rnd%0d.wr", r));
                for (int k = 1; k < m; k++) push_tx(data[k]);
            end
            g0 = got_q.size();
            spi_frame(pol, pha, lsb, nb, 99);
            check($sformatf("rnd%0d.rx_count", r), 32'(got_q.size() - g0), 32'(nb));
            for (int k = 0; k < nb; k++) begin
                exp_mi = (k < m) ? data[k] : 8'hFF;
                check($sformatf("rnd%0d.master_rx%0d", r, k), 32'(m_rx[k]), 32'(exp_mi));
                if (got_q.size() > g0 + k)
                    check($sformatf("rnd%0d.rx%0d", r, k), 32'(got_q[g0+k]), 32'(m_tx[k]));
            end
            check($sformatf("rnd%0d.tx_ready", r), 32'(ifc.tx_ready), 32'd1);
        end

        // Two bytes without reads: overrun keeps the first, otherwise the last wins.
        auto_read = 1'b0;
        repeat (4) @(negedge PCLK);
        check("ovr.pre_rx_valid", 32'(ifc.rx_valid), 32'd0);
        m_tx[0] = 8'h11; m_tx[1] = 8'h22;
        spi_frame(1'b0, 1'b0, 1'b0, 2, 99);
        check("ovr.rx_valid", 32'(ifc.rx_valid), 32'd1);
`ifdef SPI_SLAVE_OVR_EN
        check("ovr.rx_data", 32'(ifc.rx_data), 32'h11);
        check("ovr.overrun", 32'(ifc.overrun), 32'd1);
        do_read();
        check("ovr.overrun_clr", 32'(ifc.overrun), 32'd0);
`else
        check("ovr.rx_data", 32'(ifc.rx_data), 32'h22);
        do_read();
`endif
        check("ovr.rx_valid_clr", 32'(ifc.rx_valid), 32'd0);

        // Reset in the middle of a byte with a pending rx byte and a full tx buffer.
        m_tx[0] = 8'h5A;
        spi_frame(1'b0, 1'b0, 1'b0, 1, 99);
        check("rst.pre_rx_data", 32'(ifc.rx_data), 32'h5A);
        push_tx(8'h99);
        wait_tx_drain("rst.wr");
        check("rst.pre_tx_ready", 32'(ifc.tx_ready), 32'd0);
        ifc.cpol = 1'b0; ifc.cpha = 1'b0; ifc.lsbfe = 1'b0; ifc.sclk = 1'b0;
        ifc.ss = 1'b0;
        repeat (6) @(negedge PCLK);
        for (int i = 0; i < 3; i++) begin
            ifc.mosi = 1'b1;
            repeat (H) @(negedge PCLK);
            ifc.sclk = 1'b1;
            repeat (H) @(negedge PCLK);
            ifc.sclk = 1'b0;
        end
        repeat (H) @(negedge PCLK);
        ifc.sclk = 1'b1;
        repeat (4) @(negedge PCLK);
        check("rst.pre_miso_oe", 32'(ifc.miso_oe), 32'd1);
        PRESET = 1'b1;
        @(negedge PCLK);
        PRESET = 1'b0;
        check_reset("rst_mid");
        ifc.sclk = 1'b0;
        ifc.ss = 1'b1;
        ifc.mosi = 1'b0;
        repeat (10) @(negedge PCLK);
        m_tx[0] = 8'hA7;
        spi_frame(1'b0, 1'b0, 1'b0, 1, 99);
        check("rst.after_master_rx", 32'(m_rx[0]), 32'hFF);
        check("rst.after_rx_data", 32'(ifc.rx_data), 32'hA7);
        check("rst.after_rx_valid", 32'(ifc.rx_valid), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/spi_slave_responder.md
# spi_slave_responder

SPI peripheral-side (slave) endpoint that responds to the SPI master's `ss`/`sclk`/`mosi` and drives `miso`, all in the PCLK domain. It oversamples the SPI pins, supports all four CPOL/CPHA modes and MSB/LSB-first ordering, and exchanges one byte per frame slot with local logic. Local logic uses a one-entry transmit buffer with a valid/ready handshake and a one-entry receive holding register. It is the counterpart the team uses to emulate an SPI device against the master.

## Interface
- No parameters; data width fixed at 8 bits.
- `PCLK` in 1: system clock; every flop in the block is clocked on its rising edge.
- `PRESET` in 1: reset, synchronous and active-high.
- `cpol` in 1: clock idle level; captured at frame start.
- `cpha` in 1: 0 = sample on leading edge, 1 = sample on trailing edge; captured at frame start.
- `lsbfe` in 1: 1 = LSB first; captured at frame start.
- `ss` in 1: slave select, active-low, asynchronous to PCLK.
- `sclk` in 1: SPI clock from the master, asynchronous.
- `mosi` in 1: serial data from the master, asynchronous.
- `miso` out 1: serial data to the master; 0 when `miso_oe` = 0.
- `miso_oe` out 1: output enable for the `miso` pad; 1 while the frame is active.
- `tx_data` in 8: byte to transmit.
- `tx_valid` in 1: `tx_data` is valid.
- `tx_ready` out 1: transmit buffer empty; a write occurs when `tx_valid && tx_ready`.
- `rx_data` out 8: last received byte.
- `rx_valid` out 1: `rx_data` holds an unread byte (level).
- `rx_read` in 1: single-cycle pulse that consumes `rx_data`.
- `overrun` out 1: sticky overrun flag; present only with `SPI_SLAVE_OVR_EN`.
- `busy` out 1: frame active (synchronized `ss` low).

## Operation
- Synchronizers:
  - `ss`, `sclk` and `mosi` each pass through 2 flops.
  - A third `sclk` flop provides edge detection.
  - Leading edge = `sclk` rising if `cpol` = 0, falling if `cpol` = 1; trailing edge is the opposite.
- States:
  - IDLE: synchronized `ss` high; `miso_oe` = 0; bit counter = 0.
  - LOAD: one cycle after `ss` is seen low. Capture `cpol`/`cpha`/`lsbfe`. Load the shift register from the tx buffer, or 0xFF if the buffer is empty. Set `miso_oe` = 1 and drive the first bit (bit 7, or bit 0 if `lsbfe`). Go to SHIFT.
  - SHIFT: on each sample edge, shift the synchronized `mosi` into the receive shift register and increment the 3-bit counter. On each drive edge, present the next tx bit.
    - `cpha` = 1: the first leading edge is a drive edge and re-presents bit 0 of the sequence (no advance); advancement begins on the second drive edge.
    - After the 8th sample: move the receive shift register to `rx_data` and set `rx_valid`. If `ss` is still low, reload the tx shift register (buffer or 0xFF) in the same cycle and continue with counter = 0.
- Transmit buffer:
  - Accepts a write only when empty.
  - A write and a shift-register load in the same cycle: the load uses the pre-cycle content (0xFF if empty); the written byte is kept for the next slot.
- `rx_read` clears `rx_valid`. If `rx_read` coincides with a byte completion, `rx_valid` stays 1 with the new byte and no overrun is raised.
- `ss` deasserted mid-byte: return to IDLE next cycle and discard the partial byte. A byte already loaded into the shift register is lost; the tx buffer is untouched.
- Reset, including mid-frame, forces these values: `miso` 0, `miso_oe` 0, `tx_ready` 1 (buffer empty), `rx_data` 0x00, `rx_valid` 0, `overrun` 0, `busy` 0, state IDLE. Synchronizer flops reset to `ss` = 1 and `sclk` = `cpol`.

## Timing
- Pin to internal event: a pin edge becomes visible to the edge detector 3 PCLK cycles later.
- `busy`/LOAD: `busy` rises 2 cycles after `ss` falls. LOAD follows 1 cycle after that, so `miso` is valid 3 cycles after `ss` falls.
- Master constraints:
  - `ss` fall to the first `sclk` edge must be ≥ 4 PCLK.
  - Each `sclk` phase must be ≥ 4 PCLK, so sclk ≤ PCLK/8.
  - `mosi` must be stable ±1 PCLK around the sample edge plus the synchronizer delay.
- `miso` update: 1 cycle after the detected drive edge.
- `rx_valid` rises 1 cycle after the detected 8th sample edge.
- `tx_ready` falls the cycle after an accepted write and rises the cycle after the buffer is moved into the shift register.

## Configuration
- `SPI_SLAVE_OVR_EN` defined:
  - A byte completing while `rx_valid` = 1 (and no simultaneous `rx_read`) is discarded; `rx_data` keeps the old byte.
  - `overrun` goes to 1 and stays 1 until the next `rx_read`, which clears it together with `rx_valid`.
- `SPI_SLAVE_OVR_EN` undefined: the `overrun` port and its logic are absent, and a new byte overwrites `rx_data` unconditionally.

## Test plan
- Mode 0 (`cpol` 0, `cpha` 0), `lsbfe` 0, tx 0xA5 written before `ss` falls, master sends 0x3C -> master receives 0xA5; `rx_data` = 0x3C; `rx_valid` = 1; `tx_ready` back to 1.
- Mode 3, `lsbfe` 1, two back-to-back bytes under one `ss` (tx 0x81 then 0x7E, master sends 0x12, 0x34), with `rx_read` after each byte -> master receives 0x81, 0x7E; `rx_data` sequence 0x12, 0x34.
- Empty tx buffer, mode 1, master sends 0x55 -> master receives 0xFF; `rx_data` = 0x55.
- `ss` raised after 5 bits, then a full frame with master sending 0xC3 -> no `rx_valid` after the aborted frame; the next frame yields 0xC3; `miso_oe` is 0 between frames.
- With `SPI_SLAVE_OVR_EN`: two bytes 0x11 and 0x22 with no `rx_read` -> `rx_data` = 0x11, `overrun` = 1; `rx_read` clears both. Without the macro -> `rx_data` = 0x22.
- `PRESET` asserted mid-byte -> next cycle all outputs at reset values; the following frame works normally.
